ctrl_fsm: RTL
=============

// Module: ctrl_fsm
// PURPOSE
//  Sequencer directly upstream of the X_buffer / ALU / wb / sram_wrapper datapath.
//  On one start pulse it runs a full job in order:
//  - drives input_load_en until X_buffer reports xload_done;
//  - drives ALU_en until the ALU reports ALU_done;
//  - opens the SRAM for a burst readout of NUM_WORDS result words.
//  A watchdog flags a stalled datapath.
// PARAMETERS
//  NUM_WORDS  16    result words read back from SRAM per job (>=1)
//  CNT_W      8     width of rd_cnt; must satisfy 2**CNT_W >= NUM_WORDS
//  TIMEOUT    1023  max cycles allowed in LOAD or COMPUTE before error
//  TO_W       10    width of watchdog counter; 2**TO_W > TIMEOUT
// PORTS
//  clk            in   1      system clock, rising edge
//  rst            in   1      asynchronous reset, active-low
//  start          in   1      job request; sampled only in IDLE
//  err_clr        in   1      clears ERROR state and err flag
//  xload_done     in   1      from X_buffer: input load complete
//  ALU_done       in   1      from ALU: all products written back
//  input_load_en  out  1      to X_buffer: accept X_load bytes
//  ALU_en         out  1      to ALU: run compute
//  cs_n           out  1      to sram_wrapper: chip select, active-low
//  ry             out  1      to sram_wrapper: read strobe
//  rd_cnt         out  CNT_W  index of current readout word
//  busy           out  1      high in LOAD, COMPUTE, READ
//  done           out  1      one-cycle pulse at job completion
//  err            out  1      sticky watchdog error
// BEHAVIOUR
//  - All outputs are registered (Moore). Outputs change on the clk edge that enters a state.
//  - rst low, at any time including mid-job: immediately forces state IDLE and sets
//    input_load_en=0, ALU_en=0, cs_n=1, ry=0, rd_cnt=0, busy=0, done=0, err=0.
//  - States and transitions:
//    IDLE:    all strobes inactive. start=1 -> LOAD on next edge.
//    LOAD:    input_load_en=1, busy=1. xload_done=1 -> COMPUTE; input_load_en drops on the same edge.
//    COMPUTE: ALU_en=1, busy=1. ALU_done=1 -> READ; ALU_en drops on the same edge.
//    READ:    cs_n=0, ry=1, busy=1. rd_cnt = 0,1,...,NUM_WORDS-1, one per cycle.
//             After the cycle with rd_cnt=NUM_WORDS-1 -> DONE; cs_n=1, ry=0, rd_cnt=0.
//             READ lasts exactly NUM_WORDS cycles.
//    DONE:    done=1 for exactly one cycle, busy=0 -> IDLE.
//    ERROR:   all strobes inactive, err=1. err_clr=1 -> IDLE, err=0.
//  - Watchdog: counter cleared on entry to LOAD and to COMPUTE, increments each cycle in those
//    states. When it reaches TIMEOUT with no done input -> ERROR.
//    A done input in the same cycle as the timeout wins: normal transition, no error.
//  - start is ignored outside IDLE, including in DONE and ERROR.
//    A start held high continuously re-launches a job in the cycle after DONE returns to IDLE.
//  - xload_done is ignored outside LOAD; ALU_done is ignored outside COMPUTE. Stray pulses have no effect.
//  - err_clr is ignored outside ERROR. start and err_clr together in ERROR -> IDLE only;
//    start must be re-sampled in IDLE.
//  - Latency, start sampled to first input_load_en: 1 cycle.
//    Minimum job, with xload_done and ALU_done each high in the first cycle of their state:
//    1+1+1+NUM_WORDS+1 cycles from start to the done pulse.
// TESTING
//  1. Reset then start pulse; xload_done at LOAD cycle 5; ALU_done at COMPUTE cycle 20.
//     -> input_load_en high 5 cycles, ALU_en high 20 cycles, cs_n low / ry high 16 cycles
//     with rd_cnt 0..15, single done pulse, busy low after.
//  2. Start held high for 3 jobs -> three back-to-back jobs, each separated by the DONE and IDLE cycles;
//     xload_done/ALU_done pulses in IDLE or READ cause no state change.
//  3. xload_done never asserted -> after 1023 LOAD cycles err=1, input_load_en=0, cs_n=1;
//     start ignored; err_clr -> IDLE with err=0.
//  4. ALU_done asserted in exactly the timeout cycle -> READ entered, err stays 0.
//  5. rst driven low mid-READ (rd_cnt=7), asynchronously between edges
//     -> all outputs reach reset values without a clock edge; after release, idle until start.
//  6. NUM_WORDS=1 build -> READ lasts one cycle with rd_cnt=0, done follows next cycle.

Source files
------------

// File: rtl/ctrl_fsm.sv
// Job sequencer for the X_buffer / ALU / SRAM readout datapath.
// One start pulse runs load, compute and a NUM_WORDS burst read, with a watchdog on the waits.
module ctrl_fsm #(
  parameter int NUM_WORDS = 16,
  parameter int CNT_W     = 8,
  parameter int TIMEOUT   = 1023,
  parameter int TO_W      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             err_clr,
  input  logic             xload_done,
  input  logic             ALU_done,
  output logic             input_load_en,
  output logic             ALU_en,
  output logic             cs_n,
  output logic             ry,
  output logic [CNT_W-1:0] rd_cnt,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    READ,
    DONE_S,
    ERROR
  } state_t;

  // wd holds the number of cycles already spent in the current wait state,
  // so the TIMEOUT-th cycle of LOAD or COMPUTE is the one with wd == TIMEOUT-1.
  localparam logic [TO_W-1:0]  WD_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(NUM_WORDS - 1);

  state_t           state, state_next;
  logic [TO_W-1:0]  wd, wd_next;
  logic [CNT_W-1:0] rd_cnt_next;
  logic             timeout;

  always_comb begin
    state_next  = state;
    rd_cnt_next = '0;
    timeout     = (wd == WD_LAST);
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD: begin
        if (xload_done)   state_next = COMPUTE;
        else if (timeout) state_next = ERROR;
      end
      COMPUTE: begin
        if (ALU_done)     state_next = READ;
        else if (timeout) state_next = ERROR;
      end
      READ: begin
        if (rd_cnt == RD_LAST) state_next = DONE_S;
        else                   rd_cnt_next = rd_cnt + 1'b1;
      end
      DONE_S:  state_next = IDLE;
      ERROR:   if (err_clr) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    wd_next = '0;
    if ((state_next == state) && ((state == LOAD) || (state == COMPUTE)))
      wd_next = wd + 1'b1;
  end

  // Outputs are decoded from the next state so every strobe is a flop output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      wd            <= '0;
      rd_cnt        <= '0;
      input_load_en <= 1'b0;
      ALU_en        <= 1'b0;
      cs_n          <= 1'b1;
      ry            <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_next;
      wd            <= wd_next;
      rd_cnt        <= rd_cnt_next;
      input_load_en <= (state_next == LOAD);
      ALU_en        <= (state_next == COMPUTE);
      cs_n          <= (state_next != READ);
      ry            <= (state_next == READ);
      busy          <= (state_next == LOAD) || (state_next == COMPUTE) || (state_next == READ);
      done          <= (state_next == DONE_S);
      err           <= (state_next == ERROR);
    end
  end

endmodule
